// File: rtl/rr_arb_mux.sv
// Round-robin N:1 stream mux with a single registered output stage.
// Optional packet lock (in_last/out_last) enabled by defining RRMUX_PKT_LOCK_EN.
module rr_arb_mux #(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef RRMUX_PKT_LOCK_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  logic [NCH-1:0][WIDTH-1:0] ch_data;
  logic [SELW-1:0]           ptr;
  logic [SELW-1:0]           grant;
  logic [SELW:0]             sum;
  logic                      found;
  logic                      load_en;
  logic                      xfer;

`ifdef RRMUX_PKT_LOCK_EN
  logic                      locked;
  logic [SELW-1:0]           lock_ch;
`endif

  assign ch_data = in_data;
  assign load_en = ~out_valid | out_ready;
  assign xfer    = load_en & found;

  // Search ptr+1 .. ptr+NCH with explicit wrap so non-power-of-2 NCH never
  // yields an out-of-range index; first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= NCH; k++) begin
      sum = {1'b0, ptr} + (SELW+1)'(k);
      if (sum >= (SELW+1)'(NCH))
        sum = sum - (SELW+1)'(NCH);
      if (!found && in_valid[sum[SELW-1:0]]) begin
        found = 1'b1;
        grant = sum[SELW-1:0];
      end
    end
`ifdef RRMUX_PKT_LOCK_EN
    // Mid-packet the grant is pinned even if the owner pauses.
    if (locked) begin
      grant = lock_ch;
      found = in_valid[lock_ch];
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++)
      in_ready[i] = load_en & found & (grant == SELW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SELW'(NCH-1);
`ifdef RRMUX_PKT_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[grant];
      out_sel   <= grant;
`ifdef RRMUX_PKT_LOCK_EN
      out_last  <= in_last[grant];
      locked    <= ~in_last[grant];
      lock_ch   <= grant;
      if (in_last[grant])
        ptr <= grant;
`else
      ptr       <= grant;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: NCH=4 main instance plus an NCH=3 wrap instance.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
`ifdef RRMUX_PKT_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
  logic [2:0]  in3_last;
  logic        out3_last;
`endif

  logic [23:0] in3_data;
  logic [2:0]  in3_valid;
  logic [2:0]  in3_ready;
  logic [7:0]  out3_data;
  logic        out3_valid;
  logic        out3_ready;
  logic [1:0]  out3_sel;

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(.NCH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef RRMUX_PKT_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel)
  );

  rr_arb_mux #(.NCH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in3_data), .in_valid(in3_valid), .in_ready(in3_ready),
`ifdef RRMUX_PKT_LOCK_EN
    .in_last(in3_last), .out_last(out3_last),
`endif
    .out_data(out3_data), .out_valid(out3_valid), .out_ready(out3_ready),
    .out_sel(out3_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b1;
    in_data    = '0;
    in_valid   = '0;
    out_ready  = 1'b0;
    in3_data   = '0;
    in3_valid  = '0;
    out3_ready = 1'b1;
`ifdef RRMUX_PKT_LOCK_EN
    in_last    = '1;
    in3_last   = '1;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    #6 rst_n = 1'b1;

    // All four channels valid: one word per cycle, 0,1,2,3,0,...
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1 chk("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_sel",   32'(out_sel),   32'(k % 4));
      chk("rr_data",  32'(out_data),  32'(8'h10 + k % 4));
      chk("rr_ready", 32'(in_ready),  32'(1 << ((k + 1) % 4)));
    end

    // Sparse request set: 0 and 2 alternate, 1 and 3 never granted.
    in_valid = 4'b0101;
    #1 chk("alt_first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt_sel",  32'(out_sel),  32'((k % 2) * 2));
      chk("alt_data", 32'(out_data), 32'(8'h10 + (k % 2) * 2));
      chk("alt_ready", 32'(in_ready), (k % 2 == 0) ? 32'b0100 : 32'b0001);
    end

    // Load channel 1, then stall the consumer for 5 cycles.
    in_valid = 4'b0010;
    in_data  = {8'h13, 8'h12, 8'hA5, 8'h10};
    #1 chk("ld1_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("ld1_sel",  32'(out_sel),  32'd1);
    chk("ld1_data", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_ready", 32'(in_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data",  32'(out_data),  32'hA5);
      chk("stall_sel",   32'(out_sel),   32'd1);
    end
    out_ready = 1'b1;
    #1 chk("unstall_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("unstall_sel",  32'(out_sel),  32'd2);
    chk("unstall_data", 32'(out_data), 32'h12);

    // Park the NCH=4 instance holding a word while the NCH=3 instance runs.
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    in3_data  = {8'h22, 8'h21, 8'h20};
    in3_valid = 3'b111;
    #1 chk("n3_first_ready", 32'(in3_ready), 32'b001);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("n3_sel",  32'(out3_sel),  32'(k % 3));
      chk("n3_data", 32'(out3_data), 32'(8'h20 + k % 3));
    end
    chk("park_valid", 32'(out_valid), 32'd1);
    chk("park_sel",   32'(out_sel),   32'd2);

    // Asynchronous reset between edges clears the output stage at once.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sel",   32'(out_sel),   32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_valid3", 32'(out3_valid), 32'd0);
    #1 rst_n = 1'b1;
    in3_valid = 3'b000;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 32'b0001);
    tick();
    chk("post_rst_sel",  32'(out_sel),  32'd0);
    chk("post_rst_data", 32'(out_data), 32'h10);

    // Idle cycles drain the stage but must not move the pointer.
    in_valid = 4'b0000;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_data",  32'(out_data),  32'h10);
    chk("idle_sel",   32'(out_sel),   32'd0);
    tick();
    in_valid = 4'b1111;
    #1 chk("idle_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("idle_next_sel", 32'(out_sel), 32'd1);

`ifdef RRMUX_PKT_LOCK_EN
    // Channel 2 sends a 3-word packet while 0 and 1 also request.
    in_valid = 4'b0111;
    in_last  = 4'b1011;
    in_data  = {8'h13, 8'h30, 8'h11, 8'h10};
    #1 chk("pkt_ready0", 32'(in_ready), 32'b0100);
    tick();
    chk("pkt_sel0",  32'(out_sel),  32'd2);
    chk("pkt_data0", 32'(out_data), 32'h30);
    chk("pkt_last0", 32'(out_last), 32'd0);
    chk("pkt_lock_ready", 32'(in_ready), 32'b0100);
    in_data = {8'h13, 8'h31, 8'h11, 8'h10};
    tick();
    chk("pkt_sel1",  32'(out_sel),  32'd2);
    chk("pkt_data1", 32'(out_data), 32'h31);
    chk("pkt_last1", 32'(out_last), 32'd0);
    in_data = {8'h13, 8'h32, 8'h11, 8'h10};
    in_last = 4'b1111;
    tick();
    chk("pkt_sel2",  32'(out_sel),  32'd2);
    chk("pkt_data2", 32'(out_data), 32'h32);
    chk("pkt_last2", 32'(out_last), 32'd1);
    in_valid = 4'b0011;
    tick();
    chk("pkt_after_sel", 32'(out_sel), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel successor to the team's 2:1 select mux.
- Selects among NCH streaming sources by round-robin arbitration rather than an external select line.
- Registers the winner into a single-entry output stage with valid/ready handshakes on every side.
- Sits between multiple producers and one shared consumer, such as a shared bus or result writeback.

Parameters:
- NCH, 4, number of input channels; legal range 2..16, non-power-of-2 allowed.
- WIDTH, 8, data bits per channel.
- SELW, $clog2(NCH), localparam giving the width of the channel index.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- in_data  input  NCH*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel request.
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output stage holds data.
- out_ready  input  1  consumer accept.
- out_sel  output  SELW  channel index of the data in the output stage.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, ptr=NCH-1. With these values channel 0 has top priority first.
- load_en = ~out_valid | out_ready. Pipelined; no bubble when downstream drains every cycle.
- Arbitration is combinational. Search order is ptr+1, ptr+2, ..., ptr, modulo NCH. The first channel with in_valid=1 wins, giving grant index g.
- in_ready[g] = load_en & any(in_valid). All other in_ready bits are 0.
- in_ready is 0 for all channels when load_en=0.
- Transfer on channel g when in_valid[g] & in_ready[g]. On the next clk: out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=g.
- When out_valid & out_ready and no transfer occurs: out_valid<=0. out_data and out_sel hold their last values.
- Simultaneous drain and load in one cycle: new data replaces old and out_valid stays 1. Throughput is 1 word/cycle.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sel are held constant.
- ptr updates only on a transfer. It does not move on idle cycles or stalled cycles.
- Wrap-around: from ptr=NCH-1 the search starts at channel 0. Modulo arithmetic must be correct for non-power-of-2 NCH; e.g. NCH=3 never produces index 3.
- Fairness: any continuously asserted in_valid is granted within NCH transfers.
- Sources must hold in_valid and data until accepted. The block does not check this rule.
- Reset mid-operation: the output stage is discarded immediately (out_valid=0 asynchronously) and ptr returns to NCH-1.

Optional Feature:
- Macro: RRMUX_PKT_LOCK_EN.
- Defined: adds port in_last (input, NCH) and port out_last (output, 1), registered alongside out_data.
  - After a transfer with in_last[g]=0, the grant is locked to g. Other channels get in_ready=0 even if g drops in_valid.
  - The lock releases on the transfer where in_last[g]=1.
  - Reset clears the lock and sets out_last=0.
  - ptr updates only on the releasing transfer.
- Undefined: no in_last/out_last ports; arbitration runs per word, as described above.

Test Plan:
- Reset then all in_valid=4'b1111, out_ready=1, channel i data=8'h10+i -> out_sel sequence 0,1,2,3,0,... with one word every cycle; out_data 10,11,12,13,10.
- in_valid=4'b0101, out_ready=1 -> grants alternate 0,2,0,2; in_ready[1] and in_ready[3] never asserted.
- Load channel 1 (8'hA5), then hold out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data=A5 and out_sel=1 stable, in_ready=0; release -> next grant is channel 2.
- NCH=3 build, all channels valid -> out_sel cycles 0,1,2,0; no index 3; ptr wraps correctly.
- Assert rst_n=0 asynchronously mid-stream with out_valid=1 -> out_valid drops before the next clk edge; after release, the first grant goes to channel 0.
- RRMUX_PKT_LOCK_EN: channel 2 sends 3 words (in_last on the 3rd) while channels 0 and 1 are valid -> out_sel=2,2,2 then 0; out_last=1 on the 3rd word only.
